key_scan_fifo: RTL and testbench

- Keypad matrix scanner and event buffer behind the `key_cs` chip-select of the FSMC address decoder.
- Drives keypad columns active-low one at a time, samples rows, and debounces whole scan frames.
- Pushes press/release events into a small FIFO.
- The MCU reads events over the FSMC bus while `key_cs` is low; `key_irq` flags pending events.

---
 rtl/key_scan_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_key_scan_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_fifo.sv
// rtl/key_scan_fifo.sv - keypad matrix scanner with whole-frame debounce and an FSMC-readable event FIFO
module key_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_cs,
    input  logic            noe,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic [15:0]     data_out,
    output logic            data_oe,
    output logic            key_irq
);
    localparam int NK    = ROWS * COLS;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int STB_W = $clog2(DEBOUNCE);
    localparam int IDX_W = (NK > 1) ? $clog2(NK) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NK - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Synchronisers idle high so a reset never fabricates a bus read.
    logic [ROWS-1:0] row_meta_q, row_s_q;
    logic            cs_meta_q, cs_s_q, noe_meta_q, noe_s_q, rd_act_q;
    logic            rd_act, pop_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_s_q    <= '1;
            cs_meta_q  <= 1'b1;
            cs_s_q     <= 1'b1;
            noe_meta_q <= 1'b1;
            noe_s_q    <= 1'b1;
            rd_act_q   <= 1'b0;
        end else begin
            row_meta_q <= row_in;
            row_s_q    <= row_meta_q;
            cs_meta_q  <= key_cs;
            cs_s_q     <= cs_meta_q;
            noe_meta_q <= noe;
            noe_s_q    <= noe_meta_q;
            rd_act_q   <= rd_act;
        end
    end

    assign rd_act  = ~cs_s_q & ~noe_s_q;
    assign pop_req = rd_act_q & ~rd_act;

    logic [DIV_W-1:0] div_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [COLS-1:0]  col_out_q;
    logic [NK-1:0]    frame_q, prev_q, deb_q, diff_q, frame_new;
    logic [STB_W-1:0] stable_q, stable_d;
    logic             col_tick, frame_end, accept;

    assign col_tick  = (div_q == DIV_LAST);
    assign frame_end = col_tick && (col_q == COL_LAST);

    always_comb begin
        col_d = col_q;
        if (col_tick) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
    end

    always_comb begin
        frame_new = frame_q;
        for (int c = 0; c < COLS; c++) begin
            if (col_q == COL_W'(c)) begin
                for (int r = 0; r < ROWS; r++) begin
                    frame_new[r*COLS + c] = ~row_s_q[r];
                end
            end
        end
    end

    always_comb begin
        stable_d = '0;
        if (frame_new == prev_q) begin
            stable_d = (stable_q == STB_MAX) ? STB_MAX : stable_q + 1'b1;
        end
    end

    assign accept = frame_end && (stable_d == STB_MAX) && (frame_new != deb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            col_q     <= '0;
            col_out_q <= '1;
            frame_q   <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
        end else begin
            div_q     <= col_tick ? '0 : div_q + 1'b1;
            col_q     <= col_d;
            col_out_q <= ~(COLS'(1) << col_d);
            if (col_tick) begin
                frame_q <= frame_new;
            end
            if (frame_end) begin
                prev_q   <= frame_new;
                stable_q <= stable_d;
            end
        end
    end

    typedef enum logic {ST_SCAN, ST_EMIT} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             push_req;
    logic [7:0]       push_code;

    // Frame image cannot change during EMIT: the next column capture is SCAN_DIV clocks away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
            diff_q  <= '0;
            deb_q   <= '0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (accept) begin
                        diff_q  <= frame_new ^ deb_q;
                        idx_q   <= '0;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (idx_q == IDX_LAST) begin
                        deb_q   <= frame_q;
                        state_q <= ST_SCAN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign push_req  = (state_q == ST_EMIT) && diff_q[idx_q];
    assign push_code = {frame_q[idx_q], 7'(idx_q)};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, full, do_pop, do_push;
    logic [7:0]       head_d;
    logic [15:0]      data_out_q;
    logic             key_irq_q;

    // Output word is built from next-state so it tracks the FIFO without a cycle of lag.
    always_comb begin
        full     = (count_q == CNT_FULL);
        do_pop   = pop_req && (count_q != '0);
        do_push  = push_req && (!full || do_pop);
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q;
        if (do_pop) begin
            ovf_d = 1'b0;
        end else if (push_req && full) begin
            ovf_d = 1'b1;
        end
        head_d = '0;
        if (count_d != '0) begin
            head_d = ((count_q - CNT_W'(do_pop)) == '0) ? push_code : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            data_out_q <= 16'h0000;
            key_irq_q  <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            data_out_q <= {count_d != '0, ovf_d, 6'h00, head_d};
            key_irq_q  <= (count_d != '0);
        end
    end

    assign col_out  = col_out_q;
    assign data_out = data_out_q;
    assign key_irq  = key_irq_q;
    assign data_oe  = ~key_cs & ~noe;

endmodule

// File: tb/tb_key_scan_fifo.sv
// tb/tb_key_scan_fifo.sv - directed bench for key_scan_fifo with a cycle-level behavioural model
`timescale 1ns/1ps
module tb_key_scan_fifo;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 20, DEBOUNCE = 3, FIFO_DEPTH = 4;
    localparam int NK = ROWS * COLS;
    localparam int FRAME = SCAN_DIV * COLS;

    logic        clk = 1'b0, rst_n = 1'b0, key_cs = 1'b1, noe = 1'b1;
    logic [3:0]  row_in, col_out;
    logic [15:0] data_out;
    logic        data_oe, key_irq;
    logic [15:0] pressed = '0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    key_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .key_cs(key_cs), .noe(noe), .row_in(row_in),
        .col_out(col_out), .data_out(data_out), .data_oe(data_oe), .key_irq(key_irq)
    );

    // Passive keypad: a pressed key shorts its row to its column.
    always_comb begin
        row_in = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!col_out[c] && pressed[r*COLS + c]) row_in[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { int at; logic [7:0] code; } ev_t;

    int          m_cnt = 0, m_stable = 0, m_c;
    logic [15:0] m_frame = '0, m_prev = '0, m_deb = '0;
    logic [3:0]  m_col = 4'hF;
    logic        m_ovf = 1'b0, m_pop, m_full;
    bit          rd_h1 = 0, rd_h2 = 0, rd_h3 = 0;
    ev_t         m_sched[$];
    ev_t         m_ev;
    logic [7:0]  m_fifo[$];

    // m_cnt counts clock edges since reset release; edge k ends column period k/SCAN_DIV.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_stable = 0; m_frame = '0; m_prev = '0; m_deb = '0;
            m_col = 4'hF; m_ovf = 1'b0; rd_h1 = 0; rd_h2 = 0; rd_h3 = 0;
            m_sched.delete(); m_fifo.delete();
        end else begin
            m_cnt++;
            m_pop = rd_h3 && !rd_h2 && (m_fifo.size() != 0);
            m_full = (m_fifo.size() == FIFO_DEPTH);
            rd_h3 = rd_h2; rd_h2 = rd_h1; rd_h1 = ~key_cs & ~noe;
            if (m_pop) begin
                void'(m_fifo.pop_front());
                m_ovf = 1'b0;
            end
            if (m_sched.size() != 0 && m_sched[0].at == m_cnt) begin
                m_ev = m_sched.pop_front();
                if (!m_full || m_pop) m_fifo.push_back(m_ev.code);
                else m_ovf = 1'b1;
            end
            if (m_cnt % SCAN_DIV == 0) begin
                m_c = (m_cnt / SCAN_DIV - 1) % COLS;
                for (int r = 0; r < ROWS; r++) m_frame[r*COLS + m_c] = pressed[r*COLS + m_c];
                if (m_c == COLS - 1) begin
                    if (m_frame == m_prev) m_stable = (m_stable + 1 > DEBOUNCE - 1) ? DEBOUNCE - 1 : m_stable + 1;
                    else m_stable = 0;
                    m_prev = m_frame;
                    if (m_stable == DEBOUNCE - 1 && m_frame != m_deb) begin
                        for (int i = 0; i < NK; i++) begin
                            if (m_frame[i] != m_deb[i]) begin
                                m_ev.at = m_cnt + i + 1;
                                m_ev.code = {m_frame[i], 7'(i)};
                                m_sched.push_back(m_ev);
                            end
                        end
                        m_deb = m_frame;
                    end
                end
            end
            m_col = ~(4'b0001 << ((m_cnt / SCAN_DIV) % COLS));
        end
    end

    always @(negedge clk) begin
        #1;
        chk("col_out", {12'h0, col_out}, {12'h0, m_col});
        chk("data_out", data_out, (m_fifo.size() != 0) ? {1'b1, m_ovf, 6'h0, m_fifo[0]} : {1'b0, m_ovf, 14'h0});
        chk("key_irq", {15'h0, key_irq}, {15'h0, m_fifo.size() != 0});
        chk("data_oe", {15'h0, data_oe}, {15'h0, ~key_cs & ~noe});
    end

    task automatic wait_frames(input int k);
        for (int j = 0; j < k; j++) begin
            do @(negedge clk); while (!(m_cnt > 0 && m_cnt % FRAME == 0));
        end
    endtask

    task automatic wait_cnt(input int n);
        while (m_cnt < n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [15:0] exp, input string name);
        key_cs = 1'b0;
        noe = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk(name, data_out, exp);
        chk("read_oe", {15'h0, data_oe}, 16'h0001);
        @(negedge clk);
        noe = 1'b1;
        @(negedge clk);
        key_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    logic [15:0] rd_exp_a [4] = '{16'hC080, 16'h8085, 16'h808A, 16'h808F};
    logic [15:0] rd_exp_b [4] = '{16'hC000, 16'h8003, 16'h8005, 16'h800A};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d compared expected completion", n_cmp);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_col", {12'h0, col_out}, 16'h000F);
        chk("reset_data", data_out, 16'h0000);
        chk("reset_irq", {15'h0, key_irq}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        wait_cnt(30); #1;
        chk("walk_col1", {12'h0, col_out}, 16'h000D);
        wait_cnt(50); #1;
        chk("walk_col2", {12'h0, col_out}, 16'h000B);
        wait_cnt(70); #1;
        chk("walk_col3", {12'h0, col_out}, 16'h0007);

        wait_frames(1);
        pressed[6] = 1'b1;
        wait_frames(4); #1;
        chk("press_word", data_out, 16'h8086);
        chk("press_irq", {15'h0, key_irq}, 16'h0001);
        bus_read(16'h8086, "press_read");
        chk("popped_word", data_out, 16'h0000);
        chk("popped_irq", {15'h0, key_irq}, 16'h0000);

        wait_frames(1);
        pressed[6] = 1'b0;
        wait_frames(4); #1;
        chk("release_word", data_out, 16'h8006);
        bus_read(16'h8006, "release_read");

        wait_frames(1);
        for (int j = 0; j < 6; j++) begin
            pressed[6] = ~pressed[6];
            wait_frames(1);
        end
        wait_frames(2); #1;
        chk("chatter_irq", {15'h0, key_irq}, 16'h0000);
        chk("chatter_word", data_out, 16'h0000);

        pressed = 16'h8421;
        wait_frames(4); #1;
        chk("multi_head", data_out, 16'h8080);
        pressed[3] = 1'b1;
        wait_frames(4); #1;
        chk("overflow_word", data_out, 16'hC080);
        for (int j = 0; j < 4; j++) bus_read(rd_exp_a[j], "multi_read");
        chk("multi_empty", data_out, 16'h0000);

        wait_frames(1);
        pressed = '0;
        wait_frames(4); #1;
        chk("release_all", data_out, 16'hC000);
        for (int j = 0; j < 4; j++) bus_read(rd_exp_b[j], "release_all_read");
        chk("release_all_empty", data_out, 16'h0000);

        wait_frames(1);
        pressed = 16'h0116;
        wait_frames(3);
        repeat (3) @(negedge clk);
        #1;
        chk("emit_partial", data_out, 16'h8081);
        rst_n = 1'b0;
        #1;
        chk("midemit_col", {12'h0, col_out}, 16'h000F);
        chk("midemit_data", data_out, 16'h0000);
        chk("midemit_irq", {15'h0, key_irq}, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(4); #1;
        chk("reemit_word", data_out, 16'h8081);
        chk("reemit_irq", {15'h0, key_irq}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
